// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared opcodes, instruction field positions, stage entry type and decode helpers.
// Used by pipeline_stage_tracker, pipeline_hazard_detect and the pipeline controller.
package pipeline_pkg;
  localparam int IW = 32;
  localparam int RIDX_W = 4;
  localparam int OP_LSB = 28;
  localparam int FUNC_LSB = 24;
  localparam int RD_LSB = 20;
  localparam int RS1_LSB = 16;
  localparam int RS2_LSB = 12;
  localparam logic [3:0] OP_BUBBLE = 4'h0;
  localparam logic [3:0] ALUR = 4'h1;
  localparam logic [3:0] ALUI = 4'h2;
  localparam logic [3:0] LWOP = 4'h3;
  localparam logic [3:0] SWOP = 4'h4;
  localparam logic [3:0] CMPR = 4'h5;
  localparam logic [3:0] CMPI = 4'h6;
  localparam logic [3:0] BRANCH = 4'h7;
  localparam logic [3:0] JAL = 4'h8;
  typedef struct packed {
    logic valid;
    logic [3:0] op;
    logic [3:0] func;
    logic [RIDX_W-1:0] rd;
    logic [RIDX_W-1:0] rs1;
    logic [RIDX_W-1:0] rs2;
  } stage_t;
  localparam stage_t BUBBLE = '0;
  function automatic logic is_writer(input logic [3:0] op);
    return op inside {ALUR, ALUI, LWOP, CMPR, CMPI, JAL};
  endfunction
  function automatic logic uses_rs1(input logic [3:0] op);
    return op inside {ALUR, CMPR, SWOP, BRANCH, ALUI, CMPI, LWOP, JAL};
  endfunction
  function automatic logic uses_rs2(input logic [3:0] op);
    return op inside {ALUR, CMPR, SWOP, BRANCH};
  endfunction
  // true when stage s will write register idx
  function automatic logic writes(input stage_t s, input logic [RIDX_W-1:0] idx);
    return s.valid && is_writer(s.op) && s.rd == idx;
  endfunction
endpackage

// File: rtl/pipeline_hazard_detect.sv
// pipeline_hazard_detect: combinational RAW hazard check of DEC sources against EX/MEM writers.
// Ports: dec/ex/mem stage entries, ex_br_taken in; stall out.
// WB is not checked since the register file writes in the first half-cycle.
module pipeline_hazard_detect
  import pipeline_pkg::*;
(
  input  stage_t dec,
  input  stage_t ex,
  input  stage_t mem,
  input  logic   ex_br_taken,
  output logic   stall
);
  logic rs1_hit, rs2_hit;
  // r0 is hard-wired zero, so a zero source never interlocks
  assign rs1_hit = uses_rs1(dec.op) && dec.rs1 != '0 && (writes(ex, dec.rs1) || writes(mem, dec.rs1));
  assign rs2_hit = uses_rs2(dec.op) && dec.rs2 != '0 && (writes(ex, dec.rs2) || writes(mem, dec.rs2));
  // a taken branch squashes DEC, so the younger consumer no longer needs to wait
  assign stall = dec.valid && !ex_br_taken && (rs1_hit || rs2_hit);
endmodule

// File: rtl/pipeline_stage_tracker.sv
// pipeline_stage_tracker: carries instruction fields through DEC/EX/MEM/WB with hazard stall and branch flush.
// Ports: clk, reset_n (async active-low); if_instr/if_valid/ex_br_taken in;
// per-stage op/func, dec_rs1/dec_rs2, wb_rd/wb_valid, pc_wr_en/ifdec_wr_en, stall/flush,
// and saturating stall_cnt/flush_cnt out.
module pipeline_stage_tracker
  import pipeline_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [IW-1:0]     if_instr,
  input  logic              if_valid,
  input  logic              ex_br_taken,
  output logic [3:0]        if_op,
  output logic [3:0]        if_func,
  output logic [3:0]        dec_op,
  output logic [3:0]        dec_func,
  output logic [3:0]        ex_op,
  output logic [3:0]        ex_func,
  output logic [3:0]        mem_op,
  output logic [3:0]        mem_func,
  output logic [3:0]        wb_op,
  output logic [3:0]        wb_func,
  output logic [RIDX_W-1:0] dec_rs1,
  output logic [RIDX_W-1:0] dec_rs2,
  output logic [RIDX_W-1:0] wb_rd,
  output logic              wb_valid,
  output logic              pc_wr_en,
  output logic              ifdec_wr_en,
  output logic              stall,
  output logic              flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  stage_t if_e, dec_q, dec_d, ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic hz;
  logic unused_if_bits;
  assign unused_if_bits = ^if_instr[RS2_LSB-1:0];
  pipeline_hazard_detect u_hazard (
    .dec(dec_q),
    .ex(ex_q),
    .mem(mem_q),
    .ex_br_taken(ex_br_taken),
    .stall(hz)
  );
  always_comb begin
    if_e = if_valid ? stage_t'{1'b1, if_instr[OP_LSB+:4], if_instr[FUNC_LSB+:4], if_instr[RD_LSB+:RIDX_W],
                               if_instr[RS1_LSB+:RIDX_W], if_instr[RS2_LSB+:RIDX_W]} : BUBBLE;
    dec_d = ex_br_taken ? BUBBLE : hz ? dec_q : if_e;
    ex_d = (ex_br_taken || hz) ? BUBBLE : dec_q;
    mem_d = ex_q;
    wb_d = mem_q;
    stall_cnt_d = (hz && ~&stall_cnt_q) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = (ex_br_taken && ~&flush_cnt_q) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dec_q <= BUBBLE;
      ex_q <= BUBBLE;
      mem_q <= BUBBLE;
      wb_q <= BUBBLE;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      dec_q <= dec_d;
      ex_q <= ex_d;
      mem_q <= mem_d;
      wb_q <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign if_op = if_e.op;
  assign if_func = if_e.func;
  assign dec_op = dec_q.op;
  assign dec_func = dec_q.func;
  assign ex_op = ex_q.op;
  assign ex_func = ex_q.func;
  assign mem_op = mem_q.op;
  assign mem_func = mem_q.func;
  assign wb_op = wb_q.op;
  assign wb_func = wb_q.func;
  assign dec_rs1 = dec_q.rs1;
  assign dec_rs2 = dec_q.rs2;
  assign wb_rd = wb_q.rd;
  assign wb_valid = wb_q.valid;
  assign stall = hz;
  assign flush = ex_br_taken && reset_n;
  assign pc_wr_en = !hz;
  assign ifdec_wr_en = !hz;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
endmodule
